// File: rtl/carry_select_adder_rca_pipelined_n.sv
// Pipelined carry-select adder/subtractor: one BLOCK-wide slice per stage, dual RCAs selected by the registered carry.
// Latency: WIDTH/BLOCK cycles from input transfer to out_valid; one result per cycle when not stalled.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready; reset also holds in_ready low.
module carry_select_adder_rca_pipelined_n #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    function automatic logic [BLOCK:0] rca(input logic [BLOCK-1:0] x,
                                           input logic [BLOCK-1:0] y,
                                           input logic             ci);
        logic             c;
        logic [BLOCK-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_first;

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = ~rst & adv;
    assign b_eff    = sub ? ~b : b;
    assign c_first  = sub ? 1'b1 : cin;

    // Operands travel right-aligned and shrink by BLOCK bits per stage; the sum grows by BLOCK bits.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * BLOCK;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]       a_in;
        logic [RW-1:0]       b_in;
        logic                c_in;
        logic                v_in;
        logic [BLOCK:0]      r0;
        logic [BLOCK:0]      r1;
        logic [BLOCK:0]      rsel;
        logic                v_q;
        logic                c_q;
        logic [LO+BLOCK-1:0] s_q;

        if (k == 0) begin : g_src
            assign a_in = a;
            assign b_in = b_eff;
            assign c_in = c_first;
            assign v_in = in_valid;
        end else begin : g_src
            assign a_in = g_st[k-1].g_fwd.a_q;
            assign b_in = g_st[k-1].g_fwd.b_q;
            assign c_in = g_st[k-1].c_q;
            assign v_in = g_st[k-1].v_q;
        end

        assign r0   = rca(a_in[BLOCK-1:0], b_in[BLOCK-1:0], 1'b0);
        assign r1   = rca(a_in[BLOCK-1:0], b_in[BLOCK-1:0], 1'b1);
        assign rsel = c_in ? r1 : r0;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= rsel[BLOCK];
            end
        end

        if (k == 0) begin : g_sum
            always_ff @(posedge clk) begin
                if (rst)      s_q <= '0;
                else if (adv) s_q <= rsel[BLOCK-1:0];
            end
        end else begin : g_sum
            always_ff @(posedge clk) begin
                if (rst)      s_q <= '0;
                else if (adv) s_q <= {rsel[BLOCK-1:0], g_st[k-1].s_q};
            end
        end

        if (k < LAST) begin : g_fwd
            logic [RW-BLOCK-1:0] a_q;
            logic [RW-BLOCK-1:0] b_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RW-1:BLOCK];
                    b_q <= b_in[RW-1:BLOCK];
                end
            end
        end else begin : g_last
            // Carry into the MSB is recovered from the MSB's own sum bit: a ^ b ^ s.
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (rst)      ovf_q <= 1'b0;
                else if (adv) ovf_q <= rsel[BLOCK] ^ (a_in[BLOCK-1] ^ b_in[BLOCK-1] ^ rsel[BLOCK-1]);
            end
        end
    end

    assign out_valid = g_st[LAST].v_q;
    assign sum       = g_st[LAST].s_q;
    assign cout      = g_st[LAST].c_q;
    assign ovf       = g_st[LAST].g_last.ovf_q;

endmodule

// File: doc/carry_select_adder_rca_pipelined_n.md
CARRY_SELECT_ADDER_RCA_PIPELINED_N -- requirements
Module: carry_select_adder_rca_pipelined_N

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-003 Parameter BLOCK, default 8: carry-select block width in bits; WIDTH SHALL be an integer multiple of BLOCK; STAGES = WIDTH/BLOCK.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, used only when sub=0.
REQ-011 sub  input  1  0 = A+B+cin; 1 = A+~B+1 (A-B).
REQ-012 out_valid  output  1  result on sum, cout, ovf is valid.
REQ-013 out_ready  input  1  downstream accepts result this cycle.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of bit WIDTH-1; for sub=1, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement overflow: carry into bit WIDTH-1 XOR cout.

Function
REQ-017 Input accepted on a rising edge with in_valid=1 and in_ready=1 (transfer); otherwise inputs ignored.
REQ-018 Pipeline SHALL have STAGES register stages; stage k computes bits [k*BLOCK +: BLOCK].
REQ-019 Each stage computes its block with two ripple-carry adders (carry-in 0 and 1), selecting by the carry registered from stage k-1; stage 0 uses cin (sub=0) or 1 (sub=1).
REQ-020 Stage k forwards unprocessed upper operand bits, completed lower sum bits, its block carry and a valid flag to stage k+1.
REQ-021 Latency SHALL be exactly STAGES cycles from transfer to out_valid=1 when out_ready is held 1.
REQ-022 Throughput SHALL be one result per cycle with no bubbles while out_ready=1 and in_valid=1.
REQ-023 Stall: when out_valid=1 and out_ready=0, every stage SHALL hold its contents and in_ready SHALL be 0.
REQ-024 in_ready = NOT rst AND NOT (out_valid AND NOT out_ready), combinational.
REQ-025 sum, cout, ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Results SHALL leave in acceptance order, none dropped or duplicated.
REQ-027 Empty slots (valid flag 0) SHALL advance like data; out_valid=0 SHALL not block acceptance.
REQ-028 Arithmetic is modulo 2^WIDTH; cout and ovf computed from the full WIDTH-bit result only.
REQ-029 Simultaneous output handshake and input transfer SHALL both complete in the same cycle.
REQ-030 STAGES=1 (BLOCK=WIDTH) SHALL give latency 1 with identical handshake rules.

Reset
REQ-031 With rst=1 on a rising edge, all stage valid flags, out_valid, sum, cout, ovf SHALL become 0.
REQ-032 in_ready SHALL be 0 while rst=1; inputs presented during reset SHALL be discarded.
REQ-033 Reset mid-operation SHALL flush all in-flight operations; none SHALL appear at the output afterwards.

Verification (WIDTH=16, BLOCK=4, STAGES=4 unless stated)
REQ-034 a=FFFF, b=0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0000, cout=1, ovf=0.
REQ-035 a=7FFF, b=0001, cin=0, sub=0 -> sum=8000, cout=0, ovf=1; a=0005, b=0007, sub=1 -> sum=FFFE, cout=0, ovf=0.
REQ-036 Back-to-back ops 0001+0001, 0002+0002, 0003+0003 -> 0002, 0004, 0006 on consecutive cycles from cycle 4.
REQ-037 Same stream, out_ready=0 for 2 cycles when first result appears -> 0002 held, in_ready=0, then 0002, 0004, 0006 in order.
REQ-038 Two ops in flight, rst=1 one cycle -> out_valid=0 next cycle; no output for those ops.
REQ-039 WIDTH=32, BLOCK=8: 10,000 random ops with random out_ready -> all match a reference model, order preserved.
